rs_mem: RTL

Reservation station for memory instructions (LW/SW), directly upstream of `fu_mem`. It buffers dispatched memory ops until their source operands are ready and issues at most one per cycle, oldest first, whenever `fu_mem` reports ready. It snoops result broadcasts for operand wakeup and squashes wrong-path entries on a branch mispredict.

---
 rtl/rs_mem_pkg.sv | 43 ++++
 rtl/rs_mem_if.sv | 44 ++++
 rtl/rs_mem_select.sv | 60 ++++++
 rtl/rs_mem.sv | 139 +++++++++++++
 4 files changed

// File: rtl/rs_mem_pkg.sv
// rs_mem_pkg: shared types for the memory reservation station.
//   OPC_LOAD / OPC_STORE : opcodes of the two memory ops this RS handles
//   rs_data              : op fields carried from dispatch to fu_mem
//   rs_mem_entry         : one RS slot (valid, operand ready bits, op fields)
//   rob_age()            : distance of a ROB index from the ROB head (mod 32)
package rs_mem_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam int PREG_W = 7;
  localparam int ROB_W  = 5;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [ROB_W-1:0]  rob_idx_t;

  typedef struct packed {
    logic [6:0]  Opcode;
    preg_t       ps1;
    preg_t       ps2;
    preg_t       pd;
    logic [31:0] imm;
    rob_idx_t    rob_index;
  } rs_data;

  typedef struct packed {
    logic   valid;
    logic   rdy1;
    logic   rdy2;
    rs_data data;
  } rs_mem_entry;

  // Unsigned 5-bit wrap: the head itself is age 0, smaller is older.
  function automatic rob_idx_t rob_age(input rob_idx_t rob_index, input rob_idx_t rob_head);
    return rob_index - rob_head;
  endfunction

  // Loads have no second register source, so rdy2 is forced at dispatch.
  function automatic logic is_load(input rs_data d);
    return d.Opcode == OPC_LOAD;
  endfunction

endpackage

// File: rtl/rs_mem_if.sv
// rs_mem_if: dispatch, issue, wakeup and flush signals of the memory RS.
//   dispatch_valid/dispatch_data/ps1_ready_in/ps2_ready_in : new op from dispatch
//   rs_full                                                : no free entry
//   fu_mem_ready/issued/issue_data                         : issue handshake to fu_mem
//   cdb_valid/cdb_tag                                      : result broadcasts (wakeup)
//   rob_head/mispredict/mispredict_tag                     : age reference and flush
//   count                                                  : number of valid entries
// master = the surrounding pipeline, slave = rs_mem.
interface rs_mem_if #(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 3
);
  import rs_mem_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                     dispatch_valid;
  rs_data                   dispatch_data;
  logic                     ps1_ready_in;
  logic                     ps2_ready_in;
  logic                     rs_full;
  logic                     fu_mem_ready;
  logic                     issued;
  rs_data                   issue_data;
  logic [NUM_CDB-1:0]       cdb_valid;
  preg_t [NUM_CDB-1:0]      cdb_tag;
  rob_idx_t                 rob_head;
  logic                     mispredict;
  rob_idx_t                 mispredict_tag;
  logic [CNT_W-1:0]         count;

  modport master (
    output dispatch_valid, dispatch_data, ps1_ready_in, ps2_ready_in,
    output fu_mem_ready, cdb_valid, cdb_tag, rob_head, mispredict, mispredict_tag,
    input  rs_full, issued, issue_data, count
  );

  modport slave (
    input  dispatch_valid, dispatch_data, ps1_ready_in, ps2_ready_in,
    input  fu_mem_ready, cdb_valid, cdb_tag, rob_head, mispredict, mispredict_tag,
    output rs_full, issued, issue_data, count
  );

endinterface

// File: rtl/rs_mem_select.sv
// rs_mem_select: combinational oldest-eligible picker.
//   eligible     : per-entry eligible flags
//   age          : per-entry age relative to the ROB head (smaller = older)
//   rob_head     : current ROB head (ages arrive already rebased on it)
//   grant        : one-hot select of the oldest eligible entry
//   any_eligible : at least one entry is eligible
// Built as a binary tree of age comparators stored heap-style: node n has
// children 2n+1 and 2n+2, leaves occupy nodes DEPTH-1 .. 2*DEPTH-2.
module rs_mem_select
  import rs_mem_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0] eligible,
  input  rob_idx_t         age [DEPTH],
  input  rob_idx_t         rob_head,
  output logic [DEPTH-1:0] grant,
  output logic             any_eligible
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int NODES = 2 * DEPTH - 1;

  logic             node_vld [NODES];
  rob_idx_t         node_age [NODES];
  logic [IDX_W-1:0] node_idx [NODES];
  logic             take_left;

  // Ages are already rebased on the head, so the head only documents the
  // reference point of the comparison.
  logic unused_rob_head;
  assign unused_rob_head = ^rob_head;

  always_comb begin
    take_left = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      node_vld[DEPTH-1+i] = eligible[i];
      node_age[DEPTH-1+i] = age[i];
      node_idx[DEPTH-1+i] = IDX_W'(i);
    end
    // Walk from the deepest internal node up so children are resolved first.
    // Ages of valid entries are unique, so no tie-break is needed.
    for (int n = DEPTH - 2; n >= 0; n--) begin
      take_left = node_vld[2*n+1] &&
                  (!node_vld[2*n+2] || (node_age[2*n+1] < node_age[2*n+2]));
      node_vld[n] = node_vld[2*n+1] || node_vld[2*n+2];
      node_age[n] = take_left ? node_age[2*n+1] : node_age[2*n+2];
      node_idx[n] = take_left ? node_idx[2*n+1] : node_idx[2*n+2];
    end
  end

  always_comb begin
    grant        = '0;
    any_eligible = node_vld[0];
    if (node_vld[0]) begin
      grant[node_idx[0]] = 1'b1;
    end
  end

endmodule

// File: rtl/rs_mem.sv
// rs_mem: reservation station for LW/SW ahead of fu_mem.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : rs_mem_if slave (dispatch, issue handshake, CDB wakeup,
//           mispredict flush, rs_full, count)
// Buffers ops until both sources are ready, issues the oldest eligible op
// per cycle when fu_mem is ready, and squashes younger-than-branch entries
// on a mispredict.
module rs_mem
  import rs_mem_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 3
) (
  input logic     clk,
  input logic     reset,
  rs_mem_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  rs_mem_entry      ent_q [DEPTH];
  rs_mem_entry      ent_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  rs_data           last_issue_q;

  rob_idx_t         age [DEPTH];
  rob_idx_t         mp_age;
  logic [DEPTH-1:0] eligible;
  logic [DEPTH-1:0] squash;
  logic [DEPTH-1:0] grant;
  logic             any_eligible;
  logic [IDX_W-1:0] free_idx;
  logic             rs_full;
  logic             dispatch_fire;
  logic             issue_fire;
  rs_data           sel_data;
  logic [CNT_W-1:0] squash_cnt;

  function automatic logic cdb_hit(input preg_t tag,
                                   input logic [NUM_CDB-1:0] vld,
                                   input preg_t [NUM_CDB-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (vld[k] && (tags[k] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    mp_age   = rob_age(bus.mispredict_tag, bus.rob_head);
    eligible = '0;
    squash   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age[i]      = rob_age(ent_q[i].data.rob_index, bus.rob_head);
      eligible[i] = ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2;
      squash[i]   = bus.mispredict && ent_q[i].valid && (age[i] > mp_age);
    end
  end

  rs_mem_select #(.DEPTH(DEPTH)) u_select (
    .eligible     (eligible),
    .age          (age),
    .rob_head     (bus.rob_head),
    .grant        (grant),
    .any_eligible (any_eligible)
  );

  // Lowest-index free slot; the value is don't-care when the RS is full.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) free_idx = IDX_W'(i);
    end
  end

  // Full comes from registered count only, so an issue this cycle never
  // frees room for a dispatch this same cycle.
  assign rs_full       = (count_q == CNT_W'(DEPTH));
  assign dispatch_fire = bus.dispatch_valid && !rs_full && !bus.mispredict;
  assign issue_fire    = any_eligible && bus.fu_mem_ready && !bus.mispredict;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel_data = ent_q[i].data;
    end
  end

  // issue_data holds the last issued op while nothing issues.
  assign bus.issued     = issue_fire;
  assign bus.issue_data = issue_fire ? sel_data : last_issue_q;
  assign bus.rs_full    = rs_full;
  assign bus.count      = count_q;

  always_comb begin
    ent_d      = ent_q;
    squash_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid) begin
        if (cdb_hit(ent_q[i].data.ps1, bus.cdb_valid, bus.cdb_tag)) ent_d[i].rdy1 = 1'b1;
        if (cdb_hit(ent_q[i].data.ps2, bus.cdb_valid, bus.cdb_tag)) ent_d[i].rdy2 = 1'b1;
        if (issue_fire && grant[i]) ent_d[i].valid = 1'b0;
        if (squash[i]) begin
          ent_d[i].valid = 1'b0;
          squash_cnt     = squash_cnt + CNT_W'(1);
        end
      end
    end
    // The chosen slot is free, so it never collides with the issued entry.
    if (dispatch_fire) begin
      ent_d[free_idx].valid = 1'b1;
      ent_d[free_idx].data  = bus.dispatch_data;
      ent_d[free_idx].rdy1  = bus.ps1_ready_in ||
                              cdb_hit(bus.dispatch_data.ps1, bus.cdb_valid, bus.cdb_tag);
      ent_d[free_idx].rdy2  = bus.ps2_ready_in || is_load(bus.dispatch_data) ||
                              cdb_hit(bus.dispatch_data.ps2, bus.cdb_valid, bus.cdb_tag);
    end
    count_d = count_q + {{(CNT_W-1){1'b0}}, dispatch_fire}
                      - {{(CNT_W-1){1'b0}}, issue_fire}
                      - squash_cnt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q      <= '0;
      last_issue_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
      if (issue_fire) last_issue_q <= sel_data;
    end
  end

endmodule
